// File: rtl/ctrl_pipe_if.sv
// rtl/ctrl_pipe_if.sv - D-stage instruction/compare inputs and per-stage control outputs of ctrl_pipe
interface ctrl_pipe_if #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 3
);
  logic [31:0]        instr_d;
  logic               zero_d;
  logic [1:0]         pc_sel;
  logic [2:0]         npc_sel;
  logic               ext_op_d;
  logic               stall;
  logic [1:0]         fwd_rs_d;
  logic [1:0]         fwd_rt_d;
  logic [1:0]         fwd_rs_e;
  logic [1:0]         fwd_rt_e;
  logic               fwd_rt_m;
  logic [ALUOP_W-1:0] alu_op_e;
  logic               alu_src_e;
  logic               mem_wr_m;
  logic               regwr_w;
  logic [1:0]         wsel_w;
  logic [REG_AW-1:0]  waddr_w;

  modport master (
    output instr_d, zero_d,
    input  pc_sel, npc_sel, ext_op_d, stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
    input  fwd_rt_m, alu_op_e, alu_src_e, mem_wr_m, regwr_w, wsel_w, waddr_w
  );

  modport slave (
    input  instr_d, zero_d,
    output pc_sel, npc_sel, ext_op_d, stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
    output fwd_rt_m, alu_op_e, alu_src_e, mem_wr_m, regwr_w, wsel_w, waddr_w
  );
endinterface

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - pipelined MIPS control: D decode, E/M/W control words, hazards, forwarding
// Forwarding is enabled by CTRL_PIPE_FWD_EN; without it the unit is a full interlock.
module ctrl_pipe #(
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31,
  parameter int ALUOP_W  = 3
) (
  input logic        clk,
  input logic        reset,
  ctrl_pipe_if.slave bus
);
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(3);

  // use_rs/use_rt mark operands read in E; mem_wr implies rt is read in M
  typedef struct packed {
    logic               regwr;
    logic [REG_AW-1:0]  waddr;
    logic [1:0]         wsel;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               mem_wr;
    logic               is_load;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic               use_rs;
    logic               use_rt;
  } ctrl_t;

  ctrl_t dec, e_q, m_q, w_q;

  logic [5:0]        op, fn;
  logic [REG_AW-1:0] rs_d, rt_d, rd_d;
  logic              op_addu, op_subu, op_jr, op_ori, op_lui, op_lw, op_sw, op_beq, op_j, op_jal;
  logic              d_rs, d_rt, d_branch;
  logic [1:0]        pc_sel_d;
  logic [2:0]        npc_sel_d;
  logic              stall;

  assign op   = bus.instr_d[31:26];
  assign fn   = bus.instr_d[5:0];
  assign rs_d = REG_AW'(bus.instr_d[25:21]);
  assign rt_d = REG_AW'(bus.instr_d[20:16]);
  assign rd_d = REG_AW'(bus.instr_d[15:11]);

  assign op_addu = (op == 6'h00) && (fn == 6'h21);
  assign op_subu = (op == 6'h00) && (fn == 6'h23);
  assign op_jr   = (op == 6'h00) && (fn == 6'h08);
  assign op_ori  = (op == 6'h0d);
  assign op_lui  = (op == 6'h0f);
  assign op_lw   = (op == 6'h23);
  assign op_sw   = (op == 6'h2b);
  assign op_beq  = (op == 6'h04);
  assign op_j    = (op == 6'h02);
  assign op_jal  = (op == 6'h03);

  assign d_rs     = op_beq | op_jr;
  assign d_rt     = op_beq;
  assign d_branch = op_beq | op_jr;

  function automatic logic hit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

  function automatic logic reads(input logic ur, input logic ut, input logic [REG_AW-1:0] rs,
                                 input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] dst);
    return (ur && hit(rs, dst)) || (ut && hit(rt, dst));
  endfunction

  always_comb begin
    dec = '0;
    if (op_addu | op_subu)           dec.waddr = rd_d;
    else if (op_ori | op_lui | op_lw) dec.waddr = rt_d;
    else if (op_jal)                  dec.waddr = REG_AW'(LINK_REG);
    dec.regwr   = (op_addu | op_subu | op_ori | op_lui | op_lw | op_jal) && (dec.waddr != '0);
    dec.wsel    = op_lw ? 2'b01 : (op_jal ? 2'b10 : 2'b00);
    dec.alu_op  = op_subu ? ALU_SUB : (op_ori ? ALU_OR : (op_lui ? ALU_LUI : ALU_ADD));
    dec.alu_src = op_ori | op_lui | op_lw | op_sw;
    dec.mem_wr  = op_sw;
    dec.is_load = op_lw;
    dec.rs      = rs_d;
    dec.rt      = rt_d;
    dec.use_rs  = op_addu | op_subu | op_ori | op_lui | op_lw | op_sw;
    dec.use_rt  = op_addu | op_subu;
  end

  always_comb begin
    pc_sel_d  = 2'b00;
    npc_sel_d = 3'b000;
    if (op_beq) begin
      npc_sel_d = 3'b001;
      if (bus.zero_d) pc_sel_d = 2'b01;
    end else if (op_jal) begin
      npc_sel_d = 3'b010;
      pc_sel_d  = 2'b01;
    end else if (op_jr) begin
      npc_sel_d = 3'b011;
      pc_sel_d  = 2'b10;
    end else if (op_j) begin
      npc_sel_d = 3'b100;
      pc_sel_d  = 2'b01;
    end
  end

`ifdef CTRL_PIPE_FWD_EN
  // A load still in M has no result yet, so only W may feed a load's consumer
  function automatic logic [1:0] fwd_src(input logic [REG_AW-1:0] src, input ctrl_t m, input ctrl_t w);
    if (m.regwr && !m.is_load && hit(src, m.waddr)) return 2'b01;
    if (w.regwr && hit(src, w.waddr))               return 2'b10;
    return 2'b00;
  endfunction

  assign stall = (e_q.is_load && reads(d_rs | dec.use_rs, d_rt | dec.use_rt, rs_d, rt_d, e_q.waddr))
              || (d_branch && e_q.regwr && reads(d_rs, d_rt, rs_d, rt_d, e_q.waddr))
              || (d_branch && m_q.is_load && reads(d_rs, d_rt, rs_d, rt_d, m_q.waddr));

  assign bus.fwd_rs_d = d_rs ? fwd_src(rs_d, m_q, w_q) : 2'b00;
  assign bus.fwd_rt_d = d_rt ? fwd_src(rt_d, m_q, w_q) : 2'b00;
  assign bus.fwd_rs_e = e_q.use_rs ? fwd_src(e_q.rs, m_q, w_q) : 2'b00;
  assign bus.fwd_rt_e = e_q.use_rt ? fwd_src(e_q.rt, m_q, w_q) : 2'b00;
  assign bus.fwd_rt_m = m_q.mem_wr && w_q.regwr && hit(m_q.rt, w_q.waddr);
`else
  logic any_rs, any_rt;
  assign any_rs = d_rs | dec.use_rs;
  assign any_rt = d_rt | dec.use_rt | dec.mem_wr;

  assign stall = (e_q.regwr && reads(any_rs, any_rt, rs_d, rt_d, e_q.waddr))
              || (m_q.regwr && reads(any_rs, any_rt, rs_d, rt_d, m_q.waddr));

  assign bus.fwd_rs_d = 2'b00;
  assign bus.fwd_rt_d = 2'b00;
  assign bus.fwd_rs_e = 2'b00;
  assign bus.fwd_rt_e = 2'b00;
  assign bus.fwd_rt_m = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= stall ? '0 : dec;
      m_q <= e_q;
      w_q <= m_q;
    end
  end

  assign bus.stall     = stall;
  assign bus.pc_sel    = stall ? 2'b00 : pc_sel_d;
  assign bus.npc_sel   = stall ? 3'b000 : npc_sel_d;
  assign bus.ext_op_d  = (op_lw | op_sw) & ~reset;
  assign bus.alu_op_e  = e_q.alu_op;
  assign bus.alu_src_e = e_q.alu_src;
  assign bus.mem_wr_m  = m_q.mem_wr;
  assign bus.regwr_w   = w_q.regwr;
  assign bus.wsel_w    = w_q.wsel;
  assign bus.waddr_w   = w_q.waddr;

  // Stage fields kept for uniform shifting but not consumed in every stage
  logic unused_stage_bits;
  assign unused_stage_bits = ^{e_q, m_q, w_q, bus.instr_d};
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed scoreboard bench for ctrl_pipe (both CTRL_PIPE_FWD_EN builds)
module tb_ctrl_pipe;
`ifdef CTRL_PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [6:0] sb[$];

  ctrl_pipe_if #(.REG_AW(5), .ALUOP_W(3)) bus ();

  ctrl_pipe #(.REG_AW(5), .LINK_REG(31), .ALUOP_W(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input int rd, input int rs, input int rt, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Every retiring write must match the oldest expected write-back
  always @(negedge clk) begin
    if (bus.regwr_w) begin
      chk("wb_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        logic [6:0] e;
        e = sb.pop_front();
        chk("wb_waddr", 32'(bus.waddr_w), 32'(e[6:2]));
        chk("wb_wsel", 32'(bus.wsel_w), 32'(e[1:0]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] ins, input logic z, input int nstall,
                       input logic [1:0] epc, input logic [2:0] enpc, input logic [1:0] efwd);
    bus.instr_d = ins;
    bus.zero_d  = z;
    for (int k = 0; k < nstall; k++) begin
      #1;
      chk("stall_hi", 32'(bus.stall), 32'd1);
      chk("pc_sel_stalled", 32'(bus.pc_sel), 32'd0);
      chk("npc_sel_stalled", 32'(bus.npc_sel), 32'd0);
      if (k > 0) chk("bubble_e", 32'({bus.alu_op_e, bus.alu_src_e}), 32'd0);
      cyc();
    end
    #1;
    chk("stall_lo", 32'(bus.stall), 32'd0);
    if (nstall > 0) chk("bubble_e", 32'({bus.alu_op_e, bus.alu_src_e}), 32'd0);
    chk("pc_sel", 32'(bus.pc_sel), 32'(epc));
    chk("npc_sel", 32'(bus.npc_sel), 32'(enpc));
    chk("fwd_rs_d", 32'(bus.fwd_rs_d), 32'(efwd));
    cyc();
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) issue(NOP, 1'b0, 0, 2'b00, 3'b000, 2'b00);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.instr_d = NOP;
    bus.zero_d = 1'b0;
    #1;
    chk("rst_regwr_w", 32'(bus.regwr_w), 32'd0);
    chk("rst_waddr_w", 32'(bus.waddr_w), 32'd0);
    chk("rst_mem_wr_m", 32'(bus.mem_wr_m), 32'd0);
    chk("rst_alu_e", 32'({bus.alu_op_e, bus.alu_src_e}), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    cyc();
    reset = 1'b0;

    // addu $3,$1,$2 ; subu $4,$3,$1
    issue(r_op(3, 1, 2, 6'h21), 1'b0, 0, 2'b00, 3'b000, 2'b00);
    sb.push_back({5'd3, 2'b00});
    issue(r_op(4, 3, 1, 6'h23), 1'b0, FWD ? 0 : 2, 2'b00, 3'b000, 2'b00);
    sb.push_back({5'd4, 2'b00});
    bus.instr_d = NOP;
    #1;
    chk("subu_fwd_rs_e", 32'(bus.fwd_rs_e), FWD ? 32'd1 : 32'd0);
    chk("subu_fwd_rt_e", 32'(bus.fwd_rt_e), 32'd0);
    chk("subu_alu_op_e", 32'(bus.alu_op_e), 32'd1);
    drain(3);

    // lw $5,0($0) ; addu $6,$5,$5
    bus.instr_d = i_op(6'h23, 0, 5, 0);
    #1;
    chk("lw_ext_op_d", 32'(bus.ext_op_d), 32'd1);
    issue(i_op(6'h23, 0, 5, 0), 1'b0, 0, 2'b00, 3'b000, 2'b00);
    sb.push_back({5'd5, 2'b01});
    issue(r_op(6, 5, 5, 6'h21), 1'b0, FWD ? 1 : 2, 2'b00, 3'b000, 2'b00);
    sb.push_back({5'd6, 2'b00});
    bus.instr_d = NOP;
    #1;
    chk("lwuse_fwd_rs_e", 32'(bus.fwd_rs_e), FWD ? 32'd2 : 32'd0);
    chk("lwuse_fwd_rt_e", 32'(bus.fwd_rt_e), FWD ? 32'd2 : 32'd0);
    drain(3);

    // ori $7,$0,1 ; beq $7,$0 (not taken) ; beq $0,$0 (taken)
    bus.instr_d = i_op(6'h0d, 0, 7, 1);
    #1;
    chk("ori_ext_op_d", 32'(bus.ext_op_d), 32'd0);
    issue(i_op(6'h0d, 0, 7, 1), 1'b0, 0, 2'b00, 3'b000, 2'b00);
    sb.push_back({5'd7, 2'b00});
    issue(i_op(6'h04, 7, 0, 4), 1'b0, FWD ? 1 : 2, 2'b00, 3'b001, FWD ? 2'b01 : 2'b00);
    issue(i_op(6'h04, 0, 0, 4), 1'b1, 0, 2'b01, 3'b001, 2'b00);
    drain(3);

    // jal ; 3 cycles later link write ; jr $2 ; j
    issue({6'h03, 26'h10}, 1'b1, 0, 2'b01, 3'b010, 2'b00);
    sb.push_back({5'd31, 2'b10});
    issue(NOP, 1'b0, 0, 2'b00, 3'b000, 2'b00);
    issue(NOP, 1'b0, 0, 2'b00, 3'b000, 2'b00);
    #1;
    chk("jal_regwr_w", 32'(bus.regwr_w), 32'd1);
    chk("jal_waddr_w", 32'(bus.waddr_w), 32'd31);
    chk("jal_wsel_w", 32'(bus.wsel_w), 32'd2);
    issue(r_op(0, 2, 0, 6'h08), 1'b0, 0, 2'b10, 3'b011, 2'b00);
    issue({6'h02, 26'h20}, 1'b0, 0, 2'b01, 3'b100, 2'b00);
    drain(3);

    // addu $11,$1,$2 ; sw $11,0($0) -> store data from W
    issue(r_op(11, 1, 2, 6'h21), 1'b0, 0, 2'b00, 3'b000, 2'b00);
    sb.push_back({5'd11, 2'b00});
    issue(i_op(6'h2b, 0, 11, 0), 1'b0, FWD ? 0 : 2, 2'b00, 3'b000, 2'b00);
    issue(NOP, 1'b0, 0, 2'b00, 3'b000, 2'b00);
    #1;
    chk("sw_mem_wr_m", 32'(bus.mem_wr_m), 32'd1);
    chk("sw_fwd_rt_m", 32'(bus.fwd_rt_m), FWD ? 32'd1 : 32'd0);
    drain(3);

    // unknown opcode decodes as no-op
    issue(32'hFC00_FFFF, 1'b1, 0, 2'b00, 3'b000, 2'b00);
    drain(3);

    // reset pulse mid-pipeline: addu $10 in W, lw in M, sw in E
    issue(r_op(10, 1, 2, 6'h21), 1'b0, 0, 2'b00, 3'b000, 2'b00);
    issue(i_op(6'h23, 0, 9, 4), 1'b0, 0, 2'b00, 3'b000, 2'b00);
    issue(i_op(6'h2b, 0, 1, 0), 1'b0, 0, 2'b00, 3'b000, 2'b00);
    bus.instr_d = {6'h03, 26'h40};
    #1;
    chk("pre_rst_regwr_w", 32'(bus.regwr_w), 32'd1);
    chk("pre_rst_waddr_w", 32'(bus.waddr_w), 32'd10);
    chk("pre_rst_alu_src_e", 32'(bus.alu_src_e), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_regwr_w", 32'(bus.regwr_w), 32'd0);
    chk("mid_rst_waddr_w", 32'(bus.waddr_w), 32'd0);
    chk("mid_rst_mem_wr_m", 32'(bus.mem_wr_m), 32'd0);
    chk("mid_rst_alu_src_e", 32'(bus.alu_src_e), 32'd0);
    chk("mid_rst_pc_sel", 32'(bus.pc_sel), 32'd1);
    chk("mid_rst_npc_sel", 32'(bus.npc_sel), 32'd2);
    bus.instr_d = i_op(6'h23, 0, 9, 4);
    #1;
    chk("mid_rst_ext_op_d", 32'(bus.ext_op_d), 32'd0);
    #3;
    reset = 1'b0;
    bus.instr_d = NOP;
    cyc();
    drain(4);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
